// File: rtl/load_unit_pkg.sv
// Shared constants for the load unit: load-size codes, lane strobes, FSM states and
// the small helpers that map a request onto Wishbone byte lanes.
package load_unit_pkg;

  localparam logic [1:0] LOAD_NONE = 2'b00;
  localparam logic [1:0] LOAD_BYTE = 2'b01;
  localparam logic [1:0] LOAD_HALF = 2'b10;
  localparam logic [1:0] LOAD_WORD = 2'b11;

  localparam logic [3:0] STB_NONE    = 4'b0000;
  localparam logic [3:0] STB_BYTE0   = 4'b1000;
  localparam logic [3:0] STB_HALF_HI = 4'b1100;
  localparam logic [3:0] STB_HALF_LO = 4'b0011;
  localparam logic [3:0] STB_WORD    = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1
  } state_e;

  // Big-endian lanes: byte address 00 lives on bits 31:24, i.e. strobe bit 3.
  function automatic logic [3:0] lane_strobe(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] stb;
    stb = STB_NONE;
    case (size)
      LOAD_BYTE: stb = STB_BYTE0 >> a;
      LOAD_HALF: stb = a[1] ? STB_HALF_LO : STB_HALF_HI;
      LOAD_WORD: stb = STB_WORD;
      default:   stb = STB_NONE;
    endcase
    return stb;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    return ((size == LOAD_HALF) && a[0]) || ((size == LOAD_WORD) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/load_unit_extract.sv
// Combinational lane extractor: picks the addressed byte/half out of a big-endian
// 32-bit word and sign- or zero-extends it. Shared with any future fetch path.
module load_extract
  import load_unit_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_word,
  output logic [31:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte   = 8'h00;
    w_half   = 16'h0000;
    o_result = 32'h0000_0000;
    case (i_addr_lo)
      2'b00:   w_byte = i_word[31:24];
      2'b01:   w_byte = i_word[23:16];
      2'b10:   w_byte = i_word[15:8];
      default: w_byte = i_word[7:0];
    endcase
    w_half = i_addr_lo[1] ? i_word[15:0] : i_word[31:16];
    case (i_size)
      LOAD_BYTE: o_result = {{24{i_signed & w_byte[7]}}, w_byte};
      LOAD_HALF: o_result = {{16{i_signed & w_half[15]}}, w_half};
      LOAD_WORD: o_result = i_word;
      default:   o_result = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Wishbone read master for CPU loads: one aligned 32-bit read per request, lane extract,
// done/error pulses. Define LOAD_TIMEOUT_EN to abort a bus cycle after TIMEOUT_CYCLES.
module load_unit
  import load_unit_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  output logic [31:0] o_wb_addr,
  output logic        o_wb_cyc,
  output logic [3:0]  o_wb_stb,
  output logic        o_wb_we,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  input  logic [1:0]  i_load,
  input  logic        i_signed,
  input  logic [31:0] i_addr,
  output logic [31:0] o_data,
  output logic        o_done,
  output logic        o_error,
  output logic        o_busy,
  output logic [1:0]  o_dbg_state
);

  state_e      r_state, w_state_next;
  logic        r_armed, w_armed_next;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [31:0] r_addr;
  logic        r_cyc, w_cyc_next;
  logic [3:0]  r_stb, w_stb_next;
  logic [31:0] r_data, w_data_next;
  logic        r_done, w_done_next;
  logic        r_error, w_error_next;
  logic        w_accept;
  logic        w_timeout;
  logic [31:0] w_ext;

  assign w_accept = (r_state == ST_IDLE) && r_armed && (i_load != LOAD_NONE);

  load_extract u_extract (
    .i_size    (r_size),
    .i_signed  (r_signed),
    .i_addr_lo (r_addr[1:0]),
    .i_word    (i_wb_dat),
    .o_result  (w_ext)
  );

`ifdef LOAD_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = 255;
  localparam int TMO_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TMO_W-1:0] r_tmo;

  // Counts completed BUS cycles; the abort lands on the TIMEOUT_CYCLES-th BUS edge.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)                r_tmo <= '0;
    else if (w_accept)           r_tmo <= '0;
    else if (r_state == ST_BUS)  r_tmo <= r_tmo + 1'b1;
  end
  assign w_timeout = (r_state == ST_BUS) && (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state  <= ST_IDLE;
      r_armed  <= 1'b1;
      r_size   <= LOAD_NONE;
      r_signed <= 1'b0;
      r_addr   <= 32'h0;
      r_cyc    <= 1'b0;
      r_stb    <= STB_NONE;
      r_data   <= 32'h0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_armed <= w_armed_next;
      r_cyc   <= w_cyc_next;
      r_stb   <= w_stb_next;
      r_data  <= w_data_next;
      r_done  <= w_done_next;
      r_error <= w_error_next;
      if (w_accept) begin
        r_size   <= i_load;
        r_signed <= i_signed;
        r_addr   <= i_addr;
      end
    end
  end

  // Error beats ack on the same edge; ack beats a timeout landing on the same edge.
  always_comb begin
    w_state_next = r_state;
    w_armed_next = r_armed;
    w_cyc_next   = r_cyc;
    w_stb_next   = r_stb;
    w_data_next  = r_data;
    w_done_next  = 1'b0;
    w_error_next = 1'b0;
    if (i_load == LOAD_NONE) w_armed_next = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_armed_next = 1'b0;
          if (misaligned(i_load, i_addr[1:0])) begin
            w_error_next = 1'b1;
          end else begin
            w_state_next = ST_BUS;
            w_cyc_next   = 1'b1;
            w_stb_next   = lane_strobe(i_load, i_addr[1:0]);
          end
        end
      end
      ST_BUS: begin
        if (i_wb_err || i_wb_ack || w_timeout) begin
          w_state_next = ST_IDLE;
          w_cyc_next   = 1'b0;
          w_stb_next   = STB_NONE;
          if (!i_wb_err && i_wb_ack) begin
            w_data_next = w_ext;
            w_done_next = 1'b1;
          end else begin
            w_error_next = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cyc_next   = 1'b0;
        w_stb_next   = STB_NONE;
      end
    endcase
  end

  assign o_wb_addr   = {r_addr[31:2], 2'b00};
  assign o_wb_cyc    = r_cyc;
  assign o_wb_stb    = r_stb;
  assign o_wb_we     = 1'b0;
  assign o_data      = r_data;
  assign o_done      = r_done;
  assign o_error     = r_error;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_dbg_state = r_state;

endmodule
